// File: rtl/bus_terminal_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_pkg
// Description : Shared constants and helpers for the bus terminal FIFO.
//               ID_W         - width of the destination-ID field
//               BROADCAST_ID - destination ID accepted by every terminal
//               DROP_W       - width of the saturating drop counter
//               dest_of()    - extracts the destination ID of a bus word
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int              ID_W         = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
  localparam int              DROP_W       = 8;
  // Widest bus word the helper below can inspect.
  localparam int              MAX_W        = 64;

  // Destination ID is the top ID_W bits of a word that is `width` bits wide.
  // The word is passed zero-extended to MAX_W so one function serves any width.
  function automatic logic [ID_W-1:0] dest_of(input logic [MAX_W-1:0] word,
                                              input int               width);
    return ID_W'(word >> (width - ID_W));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_terminal_fifo_if.sv
`default_nettype none
// ============================================================================
// Interface   : bus_terminal_fifo_if
// Description : Host- and bus-side handshake signals of one bus terminal.
//               Host TX : wr_en, wr_data -> tx_full
//               Bus  TX : pndng, D_pop   <- pop
//               Bus  RX : push, D_push
//               Host RX : rd_en -> rd_data, rx_empty, drop_cnt
//               Modport slave is the terminal, master is whoever drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_terminal_fifo_if
  import bus_pkg::*;
#(
  parameter int ANCHO_PAL = 16
);

  logic                 wr_en;
  logic [ANCHO_PAL-1:0] wr_data;
  logic                 tx_full;
  logic                 pndng;
  logic [ANCHO_PAL-1:0] D_pop;
  logic                 pop;
  logic                 push;
  logic [ANCHO_PAL-1:0] D_push;
  logic                 rd_en;
  logic [ANCHO_PAL-1:0] rd_data;
  logic                 rx_empty;
  logic [DROP_W-1:0]    drop_cnt;

  modport slave (
    input  wr_en, wr_data, pop, push, D_push, rd_en,
    output tx_full, pndng, D_pop, rd_data, rx_empty, drop_cnt
  );

  modport master (
    output wr_en, wr_data, pop, push, D_push, rd_en,
    input  tx_full, pndng, D_pop, rd_data, rx_empty, drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/bus_terminal_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, first-word-fall-through, data output is 0
//               whenever the FIFO is empty.
//   clk        in  clock
//   reset      in  asynchronous active-low reset
//   wr_en_i    in  write strobe
//   wr_data_i  in  write word
//   rd_en_i    in  consume the head word
//   rd_data_o  out head word (0 when empty)
//   empty_o    out no words stored
//   full_o     out DEPTH words stored
// READ_FREES_SLOT=1 lets a write into a full FIFO succeed when a read
// happens in the same cycle; with 0 a full FIFO always rejects the write.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH           = 16,
  parameter int DEPTH           = 8,
  parameter bit READ_FREES_SLOT = 1'b0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             wr_en_i,
  input  wire logic [WIDTH-1:0] wr_data_i,
  input  wire logic             rd_en_i,
  output logic      [WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;

  // Flags decode registered occupancy only, never the current strobes.
  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CNT_W'(DEPTH));
  assign w_rd_ok = rd_en_i && !w_empty;
  assign w_wr_ok = wr_en_i && (!w_full || (READ_FREES_SLOT && w_rd_ok));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(w_wr_ok) - CNT_W'(w_rd_ok);
    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    if (w_wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible while count_q is zero.
  always_ff @(posedge clk) begin
    if (w_wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = w_empty ? '0 : mem_q[rd_ptr_q];
  assign empty_o   = w_empty;
  assign full_o    = w_full;

endmodule
`default_nettype wire

// File: rtl/bus_terminal_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bus_terminal_fifo
// Description : Terminal-side endpoint of the shared bus. A TX FIFO buffers
//               host words for the bus to pop; an RX FIFO keeps bus words
//               addressed to this terminal (own ID or broadcast) for the host.
//   clk    in  clock, all state on rising edge
//   reset  in  asynchronous active-low reset
//   bus    --  bus_terminal_fifo_if.slave (wr_en/wr_data/tx_full,
//              pndng/D_pop/pop, push/D_push, rd_en/rd_data/rx_empty,
//              drop_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_terminal_fifo
  import bus_pkg::*;
#(
  parameter int              ANCHO_PAL = 16,
  parameter int              DEPTH     = 8,
  parameter logic [ID_W-1:0] BROADCAST = BROADCAST_ID,
  parameter logic [ID_W-1:0] ID        = 8'h00
) (
  input wire logic          clk,
  input wire logic          reset,
  bus_terminal_fifo_if.slave bus
);

  logic              w_tx_empty;
  logic              w_rx_full;
  logic [ID_W-1:0]   w_dest;
  logic              w_match;
  logic              w_rx_accept;
  logic              w_rx_read;
  logic              w_drop;
  logic [DROP_W-1:0] drop_q;

  // TX: a full FIFO rejects writes even if the bus pops in the same cycle.
  sync_fifo #(
    .WIDTH           (ANCHO_PAL),
    .DEPTH           (DEPTH),
    .READ_FREES_SLOT (1'b0)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (bus.wr_en),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (bus.pop),
    .rd_data_o (bus.D_pop),
    .empty_o   (w_tx_empty),
    .full_o    (bus.tx_full)
  );

  assign bus.pndng = !w_tx_empty;

  assign w_dest      = dest_of(MAX_W'(bus.D_push), ANCHO_PAL);
  assign w_match     = (w_dest == ID) || (w_dest == BROADCAST);
  assign w_rx_accept = bus.push && w_match;
  assign w_rx_read   = bus.rd_en && !bus.rx_empty;

  // RX: a host read in the same cycle frees a slot for the incoming word.
  sync_fifo #(
    .WIDTH           (ANCHO_PAL),
    .DEPTH           (DEPTH),
    .READ_FREES_SLOT (1'b1)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (w_rx_accept),
    .wr_data_i (bus.D_push),
    .rd_en_i   (bus.rd_en),
    .rd_data_o (bus.rd_data),
    .empty_o   (bus.rx_empty),
    .full_o    (w_rx_full)
  );

  // Only words addressed to us can be dropped; foreign words are not losses.
  assign w_drop = w_rx_accept && w_rx_full && !w_rx_read;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (w_drop && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign bus.drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_terminal_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_terminal_fifo
// Description : Self-checking bench for bus_terminal_fifo (ID=2, DEPTH=8,
//               16-bit words). Vector table for the basic TX/RX flow,
//               queue scoreboards for fill/drain, drop and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_terminal_fifo;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  bus_terminal_fifo_if #(.ANCHO_PAL(16)) bif ();

  bus_terminal_fifo #(
    .ANCHO_PAL (16),
    .DEPTH     (8),
    .BROADCAST (8'hFF),
    .ID        (8'h02)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] tx_q [$];
  logic [15:0] rx_q [$];
  int          drop_m = 0;

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_data;
    logic        pop;
    logic        push;
    logic [15:0] d_push;
    logic        rd_en;
    logic        e_pndng;
    logic [15:0] e_d_pop;
    logic        e_tx_full;
    logic        e_rx_empty;
    logic [15:0] e_rd_data;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.wr_en   = 1'b0;
    bif.wr_data = 16'h0;
    bif.pop     = 1'b0;
    bif.push    = 1'b0;
    bif.D_push  = 16'h0;
    bif.rd_en   = 1'b0;
  endtask

  function automatic bit addr_ok(input logic [15:0] w);
    return (w[15:8] == 8'h02) || (w[15:8] == 8'hFF);
  endfunction

  // One RX cycle: optional host read plus a bus push, modelled on rx_q.
  task automatic rx_cycle(input logic [15:0] d, input logic rd);
    bif.push   = 1'b1;
    bif.D_push = d;
    bif.rd_en  = rd;
    if (rd && rx_q.size() > 0) check("rx_read_head", 32'(bif.rd_data), 32'(rx_q.pop_front()));
    if (addr_ok(d)) begin
      if (rx_q.size() < 8) rx_q.push_back(d);
      else if (drop_m < 255) drop_m++;
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // ---- reset state after 5 idle cycles
    repeat (5) tick();
    check("rst_pndng",    32'(bif.pndng),    0);
    check("rst_d_pop",    32'(bif.D_pop),    0);
    check("rst_tx_full",  32'(bif.tx_full),  0);
    check("rst_rx_empty", 32'(bif.rx_empty), 1);
    check("rst_rd_data",  32'(bif.rd_data),  0);
    check("rst_drop_cnt", 32'(bif.drop_cnt), 0);

    // ---- vector table: expected outputs after the edge that samples the row
    //        wr  wr_data   pop  push d_push    rd    pndng d_pop    full rxe  rd_data   drop
    vecs[0] = '{1'b1, 16'h0311, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0311, 1'b0, 1'b1, 16'h0000, 8'd0};
    vecs[1] = '{1'b1, 16'h0422, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0311, 1'b0, 1'b1, 16'h0000, 8'd0};
    vecs[2] = '{1'b1, 16'h0533, 1'b0, 1'b1, 16'h02AA, 1'b0, 1'b1, 16'h0311, 1'b0, 1'b0, 16'h02AA, 8'd0};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h07BB, 1'b0, 1'b1, 16'h0422, 1'b0, 1'b0, 16'h02AA, 8'd0};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFCC, 1'b0, 1'b1, 16'h0533, 1'b0, 1'b0, 16'h02AA, 8'd0};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFCC, 8'd0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'd0};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'd0};

    for (int i = 0; i < 8; i++) begin
      bif.wr_en   = vecs[i].wr_en;
      bif.wr_data = vecs[i].wr_data;
      bif.pop     = vecs[i].pop;
      bif.push    = vecs[i].push;
      bif.D_push  = vecs[i].d_push;
      bif.rd_en   = vecs[i].rd_en;
      tick();
      check($sformatf("vec%0d_pndng", i),    32'(bif.pndng),    32'(vecs[i].e_pndng));
      check($sformatf("vec%0d_d_pop", i),    32'(bif.D_pop),    32'(vecs[i].e_d_pop));
      check($sformatf("vec%0d_tx_full", i),  32'(bif.tx_full),  32'(vecs[i].e_tx_full));
      check($sformatf("vec%0d_rx_empty", i), 32'(bif.rx_empty), 32'(vecs[i].e_rx_empty));
      check($sformatf("vec%0d_rd_data", i),  32'(bif.rd_data),  32'(vecs[i].e_rd_data));
      check($sformatf("vec%0d_drop", i),     32'(bif.drop_cnt), 32'(vecs[i].e_drop));
    end
    idle_inputs();

    // ---- TX fill past full, then drain through the scoreboard
    for (int i = 1; i <= 9; i++) begin
      bif.wr_en   = 1'b1;
      bif.wr_data = 16'h0100 + 16'(i);
      if (tx_q.size() < 8) tx_q.push_back(16'h0100 + 16'(i));
      tick();
      if (i == 7) check("tx_full_after7", 32'(bif.tx_full), 0);
      if (i == 8) check("tx_full_after8", 32'(bif.tx_full), 1);
    end
    idle_inputs();
    check("tx_full_after9", 32'(bif.tx_full), 1);
    begin
      int got = 0;
      for (int k = 0; k < 20; k++) begin
        if (!bif.pndng) break;
        if (tx_q.size() == 0) check("tx_extra_word", 32'(bif.D_pop), 0);
        else check("tx_drain_word", 32'(bif.D_pop), 32'(tx_q.pop_front()));
        got++;
        bif.pop = 1'b1;
        tick();
        bif.pop = 1'b0;
      end
      check("tx_drain_count", got, 8);
      check("tx_drained_pndng", 32'(bif.pndng), 0);
      check("tx_drained_d_pop", 32'(bif.D_pop), 0);
    end

    // ---- RX fill, overflow drops, foreign word, then push+read while full
    for (int i = 0; i < 8; i++) rx_cycle(16'h0200 + 16'(i), 1'b0);
    rx_cycle(16'h0250, 1'b0);
    rx_cycle(16'hFF51, 1'b0);
    rx_cycle(16'h0752, 1'b0);
    check("rx_drop_cnt_2", 32'(bif.drop_cnt), 32'(drop_m));
    check("rx_drop_is_two", 32'(bif.drop_cnt), 2);
    rx_cycle(16'h02F0, 1'b1);
    check("rx_drop_after_rw", 32'(bif.drop_cnt), 2);
    begin
      int got = 0;
      for (int k = 0; k < 20; k++) begin
        if (bif.rx_empty) break;
        if (rx_q.size() == 0) check("rx_extra_word", 32'(bif.rd_data), 0);
        else check("rx_drain_word", 32'(bif.rd_data), 32'(rx_q.pop_front()));
        got++;
        bif.rd_en = 1'b1;
        tick();
        bif.rd_en = 1'b0;
      end
      check("rx_drain_count", got, 8);
      check("rx_drained_rd_data", 32'(bif.rd_data), 0);
    end

    // ---- reset between edges with both FIFOs occupied
    for (int i = 0; i < 3; i++) begin
      bif.wr_en = 1'b1;
      bif.wr_data = 16'h0A00 + 16'(i);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) rx_cycle(16'h0260 + 16'(i), 1'b0);
    check("pre_rst_pndng", 32'(bif.pndng), 1);
    check("pre_rst_rx_empty", 32'(bif.rx_empty), 0);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_pndng",    32'(bif.pndng),    0);
    check("mid_rst_d_pop",    32'(bif.D_pop),    0);
    check("mid_rst_tx_full",  32'(bif.tx_full),  0);
    check("mid_rst_rx_empty", 32'(bif.rx_empty), 1);
    check("mid_rst_rd_data",  32'(bif.rd_data),  0);
    check("mid_rst_drop_cnt", 32'(bif.drop_cnt), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    bif.wr_en   = 1'b1;
    bif.wr_data = 16'h0ABC;
    tick();
    idle_inputs();
    check("post_rst_pndng", 32'(bif.pndng), 1);
    check("post_rst_d_pop", 32'(bif.D_pop), 32'h0ABC);
    check("post_rst_rx_empty", 32'(bif.rx_empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
